// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: geometry constants and controller state type shared by the
// operand-memory sequencer and its output FIFO.
package mem_seq_pkg;

   localparam int unsigned MS_ROWS   = 32;
   localparam int unsigned MS_COLS   = 4;
   localparam int unsigned MS_DATA_W = 16;
   localparam int unsigned MS_ROW_W  = $clog2(MS_ROWS);
   localparam int unsigned MS_COL_W  = $clog2(MS_COLS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } ms_state_t;

endpackage

// File: rtl/mem_seq_fifo.sv
// mem_seq_fifo: 2-entry FIFO holding tagged {row, col, data} stream elements.
// The head entry is held steady until popped.
module mem_seq_fifo #(
   parameter int unsigned W = 23
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] slot_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         push_ok, pop_ok;

   // Pointer and occupancy bookkeeping; a push into a full FIFO is only
   // taken when the head leaves in the same cycle.
   always_comb begin
      pop_ok   = pop_i && (count_q != 2'd0);
      push_ok  = push_i && ((count_q != 2'd2) || pop_ok);
      wr_ptr_d = wr_ptr_q ^ push_ok;
      rd_ptr_d = rd_ptr_q ^ pop_ok;
      count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
   end

   // Storage and pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q[0] <= '0;
         slot_q[1] <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= '0;
      end else begin
         if (push_ok) slot_q[wr_ptr_q] <= din_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout_o  = slot_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: owns the single-port operand memory, sharing it between host
// writes and a row-major block reader that feeds a 2-entry output FIFO.
// Build option MEM_SEQ_INTERLEAVE_EN: host writes are granted during a stream
// in any cycle where no read is issued.
module mem_seq_ctrl
   import mem_seq_pkg::*;
#(
   parameter int unsigned ROWS   = MS_ROWS,
   parameter int unsigned COLS   = MS_COLS,
   parameter int unsigned DATA_W = MS_DATA_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [$clog2(ROWS)-1:0] wr_row,
   input  logic [$clog2(COLS)-1:0] wr_col,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    start,
   input  logic [$clog2(ROWS)-1:0] base_row,
   input  logic [$clog2(ROWS):0]   num_rows,
   output logic                    busy,
   output logic                    done,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(ROWS)-1:0] out_row,
   output logic [$clog2(COLS)-1:0] out_col,
   output logic [DATA_W-1:0]       out_data,
   output logic [31:0]             mem_row,
   output logic [3:0]              mem_col,
   output logic [DATA_W-1:0]       mem_data_in,
   output logic                    mem_en,
   input  logic [DATA_W-1:0]       mem_data_out
);

   localparam int unsigned RW = $clog2(ROWS);
   localparam int unsigned CW = $clog2(COLS);
   localparam int unsigned NW = RW + 1;
   localparam int unsigned EW = $clog2(ROWS * COLS) + 1;
   localparam int unsigned FW = RW + CW + DATA_W;

   ms_state_t         state_q, state_d;
   logic [RW-1:0]     row_q, row_d, tag_row_q, tag_row_d, arow_q, arow_d;
   logic [CW-1:0]     col_q, col_d, tag_col_q, tag_col_d, acol_q, acol_d;
   logic [DATA_W-1:0] adat_q, adat_d;
   logic [EW-1:0]     rd_left_q, rd_left_d, pop_left_q, pop_left_d;
   logic              infl_q, done_q, done_d;
   logic [1:0]        fifo_cnt;
   logic [FW-1:0]     fifo_dout;
   logic              pop, rd_issue, wr_fire, last_pop;
   logic [NW-1:0]     n_clamp;
   logic [EW-1:0]     n_elems;

   // Per-cycle grant decisions. A read is issued only if the element it
   // returns is guaranteed a FIFO slot two cycles later.
   always_comb begin
      pop      = out_valid && out_ready;
      rd_issue = (state_q == STREAM) &&
                 (({1'b0, fifo_cnt} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));
`ifdef MEM_SEQ_INTERLEAVE_EN
      wr_ready = rst_n && !rd_issue;
`else
      wr_ready = rst_n && (state_q == IDLE);
`endif
      wr_fire  = wr_valid && wr_ready;
      last_pop = (state_q == FLUSH) && pop && (pop_left_q == EW'(1));
      n_clamp  = (num_rows > NW'(ROWS)) ? NW'(ROWS) : num_rows;
      n_elems  = EW'(n_clamp) * EW'(COLS);
   end

   // Memory port mux: address/data are held whenever nothing is granted.
   always_comb begin
      arow_d = arow_q;
      acol_d = acol_q;
      adat_d = adat_q;
      if (wr_fire) begin
         arow_d = wr_row;
         acol_d = wr_col;
         adat_d = wr_data;
      end else if (rd_issue) begin
         arow_d = row_q;
         acol_d = col_q;
      end
   end

   // Sequencer next state: read pointer walk, counters and completion.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      rd_left_d  = rd_left_q;
      pop_left_d = pop_left_q;
      done_d     = 1'b0;
      tag_row_d  = rd_issue ? row_q : tag_row_q;
      tag_col_d  = rd_issue ? col_q : tag_col_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_rows != '0) begin
                  state_d    = STREAM;
                  row_d      = base_row;
                  col_d      = '0;
                  rd_left_d  = n_elems;
                  pop_left_d = n_elems;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         STREAM: begin
            if (rd_issue) begin
               rd_left_d = rd_left_q - EW'(1);
               if (col_q == CW'(COLS - 1)) begin
                  col_d = '0;
                  row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
               if (rd_left_q == EW'(1)) state_d = FLUSH;
            end
         end
         FLUSH: ;
         default: state_d = IDLE;
      endcase
      if ((state_q != IDLE) && pop) pop_left_d = pop_left_q - EW'(1);
      if (last_pop) state_d = IDLE;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         tag_row_q  <= '0;
         tag_col_q  <= '0;
         arow_q     <= '0;
         acol_q     <= '0;
         adat_q     <= '0;
         rd_left_q  <= '0;
         pop_left_q <= '0;
         infl_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         tag_row_q  <= tag_row_d;
         tag_col_q  <= tag_col_d;
         arow_q     <= arow_d;
         acol_q     <= acol_d;
         adat_q     <= adat_d;
         rd_left_q  <= rd_left_d;
         pop_left_q <= pop_left_d;
         infl_q     <= rd_issue;
         done_q     <= done_d;
      end
   end

   // Read data lands one cycle after the address and is pushed with the
   // tag captured when the read was issued.
   mem_seq_fifo #(.W(FW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (infl_q),
      .pop_i   (pop),
      .din_i   ({tag_row_q, tag_col_q, mem_data_out}),
      .dout_o  (fifo_dout),
      .count_o (fifo_cnt)
   );

   assign out_valid   = (fifo_cnt != 2'd0);
   assign {out_row, out_col, out_data} = fifo_dout;
   assign busy        = (state_q != IDLE);
   assign done        = done_q || last_pop;
   assign mem_en      = wr_fire;
   assign mem_row     = {{(32 - RW){1'b0}}, arow_d};
   assign mem_col     = {{(4 - CW){1'b0}}, acol_d};
   assign mem_data_in = adat_d;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: randomized bench for mem_seq_ctrl with an attached memory
// model and a reference image of memory contents kept from host writes.
module tb_mem_seq_ctrl;

   typedef struct packed {
      logic [4:0]  r;
      logic [1:0]  c;
      logic [15:0] d;
   } elem_t;

`ifdef MEM_SEQ_INTERLEAVE_EN
   localparam bit INTERLEAVE = 1'b1;
`else
   localparam bit INTERLEAVE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid, wr_ready;
   logic [4:0]  wr_row;
   logic [1:0]  wr_col;
   logic [15:0] wr_data;
   logic        start;
   logic [4:0]  base_row;
   logic [5:0]  num_rows;
   logic        busy, done, out_valid, out_ready;
   logic [4:0]  out_row;
   logic [1:0]  out_col;
   logic [15:0] out_data;
   logic [31:0] mem_row;
   logic [3:0]  mem_col;
   logic [15:0] mem_data_in;
   logic        mem_en;
   logic [15:0] mem_data_out = '0;

   logic [15:0] mem_model [32][4];
   logic [15:0] ref_mem   [32][4];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   mem_seq_ctrl #(.ROWS(32), .COLS(4), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
      .start(start), .base_row(base_row), .num_rows(num_rows),
      .busy(busy), .done(done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_col(out_col), .out_data(out_data),
      .mem_row(mem_row), .mem_col(mem_col), .mem_data_in(mem_data_in),
      .mem_en(mem_en), .mem_data_out(mem_data_out)
   );

   // Single-port memory: synchronous write, registered read.
   always @(posedge clk) begin
      if (mem_en) mem_model[mem_row[4:0]][mem_col[1:0]] <= mem_data_in;
      else        mem_data_out <= mem_model[mem_row[4:0]][mem_col[1:0]];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic rnd_ready(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic host_write(input int r, input int c, input logic [15:0] d);
      logic acc;
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_row = 5'(r); wr_col = 2'(c); wr_data = d;
      @(negedge clk);
      acc = wr_ready;
      check_eq("wr_ready_idle", wr_ready, 1);
      check_eq("wr_mem_en", mem_en, 1);
      @(posedge clk);
      if (acc) ref_mem[r][c] = d;
      #1 wr_valid = 1'b0;
   endtask

   // One stream transaction. hold_wr keeps a write request pending throughout,
   // cowr issues a write alongside start, mid_wr tries a write into a stall.
   task automatic run_stream(input int b, input int n, input int pct,
                             input bit hold_wr, input bit cowr, input bit mid_wr);
      elem_t       exp_q[$];
      elem_t       e, prev;
      int          total, k, got, first_k, last_k, budget, mr;
      bit          stalled;
      logic        acc;
      logic [15:0] cw_val, mid_val;
      total  = ((n > 32) ? 32 : n) * 4;
      budget = total * 8 + 40;
      cw_val = 16'($urandom);
      mr     = (b + n - 1) % 32;
      mid_val = ~ref_mem[mr][3];
      acc    = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; base_row = 5'(b); num_rows = 6'(n);
      out_ready = mid_wr ? 1'b0 : rnd_ready(pct);
      if (cowr) begin
         wr_valid = 1'b1; wr_row = 5'(b); wr_col = 2'd0; wr_data = cw_val;
      end
      @(negedge clk);
      if (cowr) begin
         acc = wr_ready;
         check_eq("cowr_ready", wr_ready, 1);
      end
      @(posedge clk);
      if (cowr && acc) ref_mem[b][0] = cw_val;
      #1;
      start = 1'b0;
      wr_valid = hold_wr;
      if (hold_wr) begin
         wr_row = 5'(b); wr_col = 2'd1; wr_data = ~ref_mem[b][1];
      end
      for (int i = 0; i < total; i++) begin
         e.r = 5'((b + i / 4) % 32);
         e.c = 2'(i % 4);
         e.d = ref_mem[e.r][e.c];
         exp_q.push_back(e);
      end
      k = 0; got = 0; first_k = -1; last_k = -1; stalled = 1'b0; acc = 1'b0;
      while (got < total && k < budget) begin
         @(negedge clk); k++;
         check_eq("busy_run", busy, 1);
         check_eq("addr_hi", {mem_row[31:5], mem_col[3:2]}, 0);
         if (hold_wr) check_eq("wr_ready_busy", wr_ready, 0);
         if (mid_wr && k == 4) begin
            acc = wr_ready;
            check_eq("mid_wr_ready", wr_ready, INTERLEAVE);
         end
         if (stalled) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_hold", {out_row, out_col, out_data}, prev);
         end
         if (out_valid) begin
            if (first_k < 0) first_k = k;
            if (out_ready) begin
               e = exp_q.pop_front();
               check_eq("elem", {out_row, out_col, out_data}, e);
               got++; last_k = k;
               check_eq("done_last", done, (got == total));
            end else begin
               check_eq("done_stall", done, 0);
            end
         end else begin
            check_eq("done_idle", done, 0);
         end
         stalled = out_valid && !out_ready;
         prev = {out_row, out_col, out_data};
         @(posedge clk);
         if (mid_wr && k == 4 && acc) begin
            ref_mem[mr][3] = mid_val;
            e = exp_q.pop_back();
            e.d = mid_val;
            exp_q.push_back(e);
         end
         #1;
         out_ready = (mid_wr && k < 4) ? 1'b0 : rnd_ready(pct);
         if (mid_wr && k == 3) begin
            wr_valid = 1'b1; wr_row = 5'(mr); wr_col = 2'd3; wr_data = mid_val;
         end else if (mid_wr && k == 4) begin
            wr_valid = 1'b0;
         end
         if (got == total) wr_valid = 1'b0;
      end
      check_eq("stream_count", got, total);
      wr_valid = 1'b0;
      @(negedge clk);
      check_eq("busy_end", busy, 0);
      check_eq("valid_end", out_valid, 0);
      check_eq("done_end", done, 0);
      if (pct == 100 && !mid_wr) begin
         check_eq("first_latency", first_k, 3);
         check_eq("back_to_back", last_k - first_k, total - 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
      start = 1'b0; base_row = '0; num_rows = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_wr_ready", wr_ready, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_mem_addr", {mem_row, mem_col}, 0);
      check_eq("rst_out_data", out_data, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_wr_ready", wr_ready, 1);

      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 4; c++)
            host_write(r, c, 16'(r * 4 + c));

      run_stream(0, 32, 100, 1'b0, 1'b0, 1'b0);
      run_stream(30, 4, 100, 1'b0, 1'b0, 1'b0);

      // Zero-length request: done pulse only, memory untouched.
      @(posedge clk); #1;
      start = 1'b1; base_row = 5'd3; num_rows = 6'd0; out_ready = 1'b1;
      @(negedge clk);
      check_eq("zero_done_early", done, 0);
      check_eq("zero_mem_en0", mem_en, 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("zero_done", done, 1);
      check_eq("zero_busy", busy, 0);
      check_eq("zero_valid", out_valid, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("zero_done_after", done, 0);
         check_eq("zero_valid_after", out_valid, 0);
         check_eq("zero_mem_en", mem_en, 0);
      end

      run_stream(0, 40, 100, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++)
         host_write(int'($urandom_range(31)), int'($urandom_range(3)), 16'($urandom));

      for (int i = 0; i < 5; i++)
         run_stream(int'($urandom_range(31)), int'($urandom_range(34, 1)), 50, 1'b0, 1'b0, 1'b0);
`ifndef MEM_SEQ_INTERLEAVE_EN
      run_stream(int'($urandom_range(31)), 8, 50, 1'b1, 1'b0, 1'b0);
`endif
      run_stream(int'($urandom_range(31)), 3, 50, 1'b0, 1'b1, 1'b0);
      run_stream(2, 4, 100, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a stream abandons it silently.
      @(posedge clk); #1;
      start = 1'b1; base_row = 5'd5; num_rows = 6'd10; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_valid", out_valid, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_done", done, 0);
      check_eq("midrst_wr_ready", wr_ready, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("midrst_no_done", done, 0);
         check_eq("midrst_no_valid", out_valid, 0);
         check_eq("midrst_idle", busy, 0);
      end
      run_stream(7, 3, 100, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_seq_ctrl.md
# mem_seq_ctrl

Controller and arbiter in front of the 32-row × 4-column × 16-bit single-port operand memory. It shares that memory between two requesters. The first is a host write port. The second is a streaming reader that emits a contiguous block of rows in row-major order toward the systolic array loader. The block owns every memory control signal: it drives row, col, data_in and en, and consumes data_out.

## Interface
Parameters:
- ROWS, 32: number of memory rows; the row index wraps modulo ROWS.
- COLS, 4: columns per row.
- DATA_W, 16: element width.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  host write request.
- wr_ready  out  1  host write accepted this cycle when wr_valid && wr_ready.
- wr_row  in  5  host write row.
- wr_col  in  2  host write column.
- wr_data  in  16  host write data.
- start  in  1  single-cycle stream request; sampled only in IDLE.
- base_row  in  5  first row of the stream; sampled with start.
- num_rows  in  6  row count; 0 means no reads, >32 is clamped to 32.
- busy  out  1  high while a stream is in progress.
- done  out  1  one-cycle pulse marking stream completion.
- out_valid  out  1  stream element available.
- out_ready  in  1  downstream accepts; transfer on out_valid && out_ready.
- out_row  out  5  row tag of the element.
- out_col  out  2  column tag of the element.
- out_data  out  16  element value.
- mem_row  out  32  memory row address; zero-extended from 5 bits.
- mem_col  out  4  memory column address; zero-extended from 2 bits.
- mem_data_in  out  16  memory write data.
- mem_en  out  1  1 = write, 0 = read.
- mem_data_out  in  16  memory read data; registered, valid the cycle after the read address.

## Operation
- States: IDLE, STREAM, FLUSH.
- IDLE:
  - wr_ready=1.
  - An accepted write drives mem_en=1 with the write address and data.
  - Otherwise mem_en=0 and the address is held.
  - start with num_rows≥1 → STREAM at the next edge. busy rises at the same edge. The element counter is loaded with min(num_rows,32)×4.
  - start with num_rows=0 → done pulses the next cycle and the state stays IDLE.
  - start and wr_valid in the same cycle: the write is performed and the stream starts next cycle.
- STREAM:
  - A read is issued when fifo_count + inflight − pop < 2, where pop = out_valid && out_ready.
  - Read order is (row, col) starting at (base_row, 0); col increments 0→3, then row increments modulo 32.
  - After the final read is issued → FLUSH.
- FLUSH:
  - No reads are issued; the block waits for in-flight data to land and the FIFO to drain.
  - On the pop of the last element: done=1 that cycle, busy falls and the state returns to IDLE at the edge.
- Returned data enters a 2-entry FIFO tagged with its row and col. out_* is the FIFO head. out_data is stable while out_valid && !out_ready.
- In STREAM and FLUSH, wr_ready=0 unless the interleave option is enabled (see Configuration).
- Reset: state IDLE, FIFO empty, counters zero, all outputs 0 (wr_ready=0 during reset, 1 after). Reset mid-stream abandons the stream with no done pulse.

## Timing
- start sampled at edge E → first read address during cycle E+1 → mem_data_out valid in E+2 → out_valid in E+3.
- Sustained throughput is 1 element per cycle with out_ready held high. A 32-row stream takes 128 consecutive out_valid cycles.
- With out_ready low, at most 2 elements are buffered and no element is lost or duplicated.
- done is asserted in the same cycle as the final out transfer.
- Write latency is 1 cycle: data is in memory after the accept edge.

## Configuration
- MEM_SEQ_INTERLEAVE_EN:
  - Defined: during STREAM and FLUSH, wr_ready=1 in any cycle where no read is issued. Host writes slip into backpressure bubbles. A write to a row still unread is visible to the stream; ordering follows memory access order.
  - Undefined: wr_ready=0 whenever busy.

## Structure
- mem_seq_pkg holds the ROWS/COLS/DATA_W constants, the row/col index widths and the state enum {IDLE, STREAM, FLUSH}.
- One sub-module, mem_seq_fifo: a 2-entry FIFO of {row, col, data} with count output, push/pop, and a flush on reset.

## Test plan
- Host writes value row*4+col to all 128 locations, then start with base_row=0, num_rows=32 and out_ready=1 → 128 consecutive elements 0..127, first out_valid 3 cycles after start, done on element 127.
- base_row=30, num_rows=4 → rows 30,31,0,1 in order, values 120..123, 124..127, 0..3, 4..7.
- num_rows=0 → done the next cycle, no out_valid, mem_en never set; num_rows=40 → exactly 128 elements.
- Random out_ready at 50% → exact in-order sequence with no drops or duplicates; out_data stable while stalled.
- wr_valid held during a stream → wr_ready=0 throughout when the macro is undefined. When defined and out_ready=0, writes are accepted, and a write to an unread row returns the new value.
- rst_n asserted mid-stream → out_valid=0, busy=0 and no done; a new start after release streams correctly.
